// File: rtl/seg_scan_ctrl.sv
// Multiplexed scan controller for a common-anode seven-segment display.
// Double-buffered digit data is swapped into the active set only at frame boundaries.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SHOW_CYCLES  = 50000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [3:0]              dig_code,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    dp_n,
  output logic                    load_ack,
  output logic                    frame_tick
);

  localparam int unsigned MAX_CYC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int unsigned TW      = $clog2(MAX_CYC + 1);
  localparam int unsigned IW      = $clog2(NUM_DIGITS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_SHOW
  } state_t;

  state_t                  r_state;
  logic [IW-1:0]           r_idx;
  logic [TW-1:0]           r_tmr;
  logic [4*NUM_DIGITS-1:0] r_sh_data, r_ac_data;
  logic [NUM_DIGITS-1:0]   r_sh_dp, r_ac_dp;
  logic [NUM_DIGITS-1:0]   r_sh_blank, r_ac_blank;
  logic                    r_pend;

  logic [3:0]              r_dig;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_dp;
  logic                    r_ack;
  logic                    r_tick;

  state_t                  w_state_nx;
  logic [IW-1:0]           w_idx_nx;
  logic [TW-1:0]           w_tmr_nx;
  logic                    w_xfer;
  logic                    w_tick_nx;
  logic [4*NUM_DIGITS-1:0] w_ac_data_nx;
  logic [NUM_DIGITS-1:0]   w_ac_dp_nx;
  logic [NUM_DIGITS-1:0]   w_ac_blank_nx;
  logic [3:0]              w_dig_nx;
  logic [NUM_DIGITS-1:0]   w_an_nx;
  logic                    w_dp_nx;

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_tmr_nx   = r_tmr;
    w_xfer     = 1'b0;
    w_tick_nx  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_state_nx = ST_BLANK;
          w_idx_nx   = '0;
          w_tmr_nx   = '0;
          w_xfer     = r_pend;
        end
      end
      ST_BLANK: begin
        if (!enable) begin
          w_state_nx = ST_IDLE;
          w_idx_nx   = '0;
          w_tmr_nx   = '0;
        end else if (r_tmr == TW'(BLANK_CYCLES - 1)) begin
          w_state_nx = ST_SHOW;
          w_tmr_nx   = '0;
        end else begin
          w_tmr_nx = r_tmr + TW'(1);
        end
      end
      ST_SHOW: begin
        if (!enable) begin
          w_state_nx = ST_IDLE;
          w_idx_nx   = '0;
          w_tmr_nx   = '0;
        end else if (r_tmr == TW'(SHOW_CYCLES - 1)) begin
          w_state_nx = ST_BLANK;
          w_tmr_nx   = '0;
          if (r_idx == IW'(NUM_DIGITS - 1)) begin
            w_idx_nx  = '0;
            w_tick_nx = 1'b1;
            w_xfer    = r_pend;
          end else begin
            w_idx_nx = r_idx + IW'(1);
          end
        end else begin
          w_tmr_nx = r_tmr + TW'(1);
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_idx_nx   = '0;
        w_tmr_nx   = '0;
      end
    endcase
  end

  // Outputs are decoded from the post-edge state and data so they register alongside it.
  always_comb begin
    w_ac_data_nx  = w_xfer ? r_sh_data  : r_ac_data;
    w_ac_dp_nx    = w_xfer ? r_sh_dp    : r_ac_dp;
    w_ac_blank_nx = w_xfer ? r_sh_blank : r_ac_blank;
    w_dig_nx      = w_ac_data_nx[{w_idx_nx, 2'b00} +: 4];
    w_an_nx       = '1;
    w_dp_nx       = 1'b1;
    if (w_state_nx == ST_SHOW) begin
      w_dp_nx = ~w_ac_dp_nx[w_idx_nx];
      if (!w_ac_blank_nx[w_idx_nx]) begin
        w_an_nx[w_idx_nx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_tmr      <= '0;
      r_sh_data  <= '0;
      r_sh_dp    <= '0;
      r_sh_blank <= '0;
      r_ac_data  <= '0;
      r_ac_dp    <= '0;
      r_ac_blank <= '0;
      r_pend     <= 1'b0;
      r_dig      <= '0;
      r_an       <= '1;
      r_dp       <= 1'b1;
      r_ack      <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_idx      <= w_idx_nx;
      r_tmr      <= w_tmr_nx;
      r_ac_data  <= w_ac_data_nx;
      r_ac_dp    <= w_ac_dp_nx;
      r_ac_blank <= w_ac_blank_nx;
      // A load coinciding with a transfer refills the shadow and keeps it pending.
      if (load) begin
        r_sh_data  <= data_in;
        r_sh_dp    <= dp_in;
        r_sh_blank <= blank_in;
        r_pend     <= 1'b1;
      end else if (w_xfer) begin
        r_pend <= 1'b0;
      end
      r_dig  <= w_dig_nx;
      r_an   <= w_an_nx;
      r_dp   <= w_dp_nx;
      r_ack  <= w_xfer;
      r_tick <= w_tick_nx;
    end
  end

  assign dig_code   = r_dig;
  assign an_n       = r_an;
  assign dp_n       = r_dp;
  assign load_ack   = r_ack;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed vector table, corner sequences, and random
// stimulus checked against a frame-position reference model.
module tb_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int SH    = 4;
  localparam int BL    = 1;
  localparam int SLOT  = SH + BL;
  localparam int FRAME = N * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic [3:0]  dig_code;
  logic [3:0]  an_n;
  logic        dp_n;
  logic        load_ack;
  logic        frame_tick;

  int n_cmp = 0;
  int n_err = 0;

  seg_scan_ctrl #(.NUM_DIGITS(N), .SHOW_CYCLES(SH), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .data_in(data_in),
    .dp_in(dp_in), .blank_in(blank_in), .dig_code(dig_code), .an_n(an_n),
    .dp_n(dp_n), .load_ack(load_ack), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: position within the frame is a plain cycle count since scanning began.
  logic [15:0] m_sh_d, m_ac_d;
  logic [3:0]  m_sh_p, m_sh_b, m_ac_p, m_ac_b;
  bit          m_pend, m_run, m_ack, m_tick;
  int          m_t;

  function automatic void model_reset();
    m_sh_d = '0; m_sh_p = '0; m_sh_b = '0;
    m_ac_d = '0; m_ac_p = '0; m_ac_b = '0;
    m_pend = 0; m_run = 0; m_ack = 0; m_tick = 0; m_t = 0;
  endfunction

  function automatic void model_xfer();
    m_ac_d = m_sh_d; m_ac_p = m_sh_p; m_ac_b = m_sh_b;
    m_ack  = 1; m_pend = 0;
  endfunction

  function automatic void model_edge();
    m_ack = 0; m_tick = 0;
    if (rst) begin
      model_reset();
      return;
    end
    if (!enable) begin
      m_run = 0;
    end else if (!m_run) begin
      m_run = 1; m_t = 0;
      if (m_pend) model_xfer();
    end else begin
      m_t = (m_t + 1) % FRAME;
      if (m_t == 0) begin
        m_tick = 1;
        if (m_pend) model_xfer();
      end
    end
    if (load) begin
      m_sh_d = data_in; m_sh_p = dp_in; m_sh_b = blank_in; m_pend = 1;
    end
  endfunction

  function automatic logic [10:0] model_out();
    int d, ph;
    logic [3:0] an, dg;
    logic dpn;
    an = '1; dpn = 1'b1; dg = m_ac_d[3:0];
    if (m_run) begin
      d  = m_t / SLOT;
      ph = m_t % SLOT;
      dg = m_ac_d[d*4 +: 4];
      if (ph >= BL) begin
        dpn = ~m_ac_p[d];
        if (!m_ac_b[d]) an = ~(4'b0001 << d);
      end
    end
    return {an, dg, dpn, m_ack, m_tick};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model", {21'd0, an_n, dig_code, dp_n, load_ack, frame_tick}, {21'd0, model_out()});
  endtask

  task automatic wait_tick(input string name);
    int k;
    for (k = 0; k < 3 * FRAME; k++) begin
      step();
      if (frame_tick) break;
    end
    check(name, k < 3 * FRAME, 1);
  endtask

  task automatic wait_an(input string name, input logic [3:0] tgt);
    int k;
    for (k = 0; k < 3 * FRAME; k++) begin
      step();
      if (an_n == tgt) break;
    end
    check(name, k < 3 * FRAME, 1);
  endtask

  typedef struct {
    bit          en;
    bit          ld;
    logic [10:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input int cnt, input bit en, input bit ld, input logic [3:0] an,
                              input logic [3:0] dg, input bit dpn, input bit ack, input bit tick);
    vec_t v;
    v.en = en; v.ld = ld; v.exp = {an, dg, dpn, ack, tick};
    for (int i = 0; i < cnt; i++) tbl.push_back(v);
  endfunction

  initial begin
    int ack_cnt, flen;
    bit ack_at_tick, seen_d1;

    add(1, 0, 1, 4'hF, 4'h0, 1, 0, 0);
    add(1, 1, 0, 4'hF, 4'h1, 1, 1, 0);
    add(4, 1, 0, 4'hE, 4'h1, 1, 0, 0);
    add(1, 1, 0, 4'hF, 4'h2, 1, 0, 0);
    add(4, 1, 0, 4'hD, 4'h2, 1, 0, 0);
    add(1, 1, 0, 4'hF, 4'h3, 1, 0, 0);
    add(4, 1, 0, 4'hB, 4'h3, 0, 0, 0);
    add(1, 1, 0, 4'hF, 4'h4, 1, 0, 0);
    add(4, 1, 0, 4'h7, 4'h4, 1, 0, 0);
    add(1, 1, 0, 4'hF, 4'h1, 1, 0, 1);

    model_reset();
    #12;
    check("reset_outputs", {an_n, dig_code, dp_n, load_ack, frame_tick}, {4'hF, 4'h0, 3'b100});
    rst = 0;

    // Directed: load while idle, then one full frame.
    for (int i = 0; i < tbl.size(); i++) begin
      enable = tbl[i].en; load = tbl[i].ld; data_in = 16'h4321; dp_in = 4'b0100;
      step();
      check($sformatf("vec%0d", i), {an_n, dig_code, dp_n, load_ack, frame_tick}, tbl[i].exp);
    end
    load = 0; dp_in = '0;

    // Two loads mid-frame: single ack at frame end, last data wins.
    step(); step(); step();
    load = 1; data_in = 16'hABCD; step();
    load = 0; step();
    load = 1; data_in = 16'h5678; step();
    load = 0;
    ack_cnt = 0; ack_at_tick = 0;
    for (int k = 0; k < FRAME; k++) begin
      step();
      if (load_ack) ack_cnt++;
      if (frame_tick) begin
        ack_at_tick = load_ack;
        break;
      end
    end
    check("dbl_load_ack_at_tick", ack_at_tick, 1);
    check("dbl_load_ack_count", ack_cnt, 1);
    step(); step();
    check("next_frame_d0", {an_n, dig_code}, {4'hE, 4'h8});
    repeat (5) step();
    check("next_frame_d1", {an_n, dig_code}, {4'hD, 4'h7});
    repeat (5) step();
    check("next_frame_d2", {an_n, dig_code}, {4'hB, 4'h6});
    repeat (5) step();
    check("next_frame_d3", {an_n, dig_code}, {4'h7, 4'h5});

    // Blanked digit 1: anode stays dark, frame length unchanged.
    load = 1; data_in = 16'h9999; blank_in = 4'b0010; step();
    load = 0;
    wait_tick("blank_apply_tick");
    check("blank_applied_ack", load_ack, 1);
    flen = 0; seen_d1 = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      flen++;
      if (an_n == 4'b1101) seen_d1 = 1;
      if (frame_tick) break;
    end
    check("blank_frame_len", flen, FRAME);
    check("blank_d1_dark", seen_d1, 0);

    // Enable dropped during digit 2's SHOW, then restored.
    wait_an("wait_d2_show", 4'b1011);
    enable = 0; step();
    check("en_drop_dark", an_n, 4'hF);
    step(); step();
    enable = 1; step();
    check("en_restart_blank", an_n, 4'hF);
    step();
    check("en_restart_d0", {an_n, dig_code}, {4'hE, 4'h9});

    // Asynchronous reset mid-SHOW.
    wait_an("wait_d0_show", 4'hE);
    #2 rst = 1;
    #1 check("async_rst", {an_n, dig_code, dp_n, load_ack, frame_tick}, {4'hF, 4'h0, 3'b100});
    model_reset();
    #1 rst = 0;
    step(); step();
    check("post_rst_data_gone", {an_n, dig_code}, {4'hE, 4'h0});

    // Random stimulus against the model.
    for (int k = 0; k < 800; k++) begin
      rst      = ($urandom_range(0, 199) == 0);
      enable   = ($urandom_range(0, 39) != 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      load     = ($urandom_range(0, 14) == 0);
      data_in  = 16'($urandom);
      dp_in    = 4'($urandom);
      blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a common-anode multi-digit seven-segment display.
- One 4-bit-to-segment decoder is shared across all digits. This block selects which digit's nibble drives that decoder and which anode is lit.
- Display data is double-buffered. New values are applied only at frame boundaries, so a frame never shows a mix of old and new digits.
- Sits between the system's numeric registers and the shared decoder plus the anode drivers.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- SHOW_CYCLES, 50000, clock cycles each digit's anode is lit per slot (>=1).
- BLANK_CYCLES, 2, clock cycles all anodes are off before each digit slot (anti-ghosting, >=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset: asynchronous assert, active-high.
- enable  in  1  1 = scanning; 0 = display dark.
- load  in  1  single-cycle request to capture new display data.
- data_in  in  4*NUM_DIGITS  digit nibbles; digit k = data_in[4k+3:4k].
- dp_in  in  NUM_DIGITS  decimal-point request per digit, 1 = on.
- blank_in  in  NUM_DIGITS  per-digit blank, 1 = anode never lit.
- dig_code  out  4  nibble presented to the shared decoder.
- an_n  out  NUM_DIGITS  anode enables, active-low, one-hot-low when lit.
- dp_n  out  1  decimal point, active-low.
- load_ack  out  1  one-cycle pulse when captured data becomes the active frame.
- frame_tick  out  1  one-cycle pulse at the end of the last digit's SHOW slot.

Behaviour:
- Reset values: an_n all 1, dp_n=1, dig_code=0, load_ack=0, frame_tick=0.
- Reset internal state: state=IDLE, digit index=0, timer=0, shadow and active registers all 0, pending=0.
- Registers:
  - shadow {data, dp, blank} plus pending flag.
  - active {data, dp, blank}.
  - digit index, range 0..NUM_DIGITS-1.
  - slot timer, width ceil(log2(max(SHOW_CYCLES, BLANK_CYCLES)+1)).
- load handling:
  - load=1 at an edge: shadow <= {data_in, dp_in, blank_in}, pending <= 1.
  - A repeated load while pending overwrites the shadow. Only one load_ack follows.
- States:
  - IDLE: an_n all 1, dp_n=1. On enable=1, go to BLANK with index 0 and timer cleared. If pending=1 on entering BLANK from IDLE, copy shadow to active and pulse load_ack in that same transition cycle.
  - BLANK: an_n all 1, dp_n=1, dig_code = active nibble of the current index. After BLANK_CYCLES cycles, go to SHOW.
  - SHOW: an_n[index]=0 unless active blank[index]=1 (then all 1). dig_code = active nibble[index]; dp_n = ~active dp[index]. After SHOW_CYCLES cycles:
    - If index < NUM_DIGITS-1: index+1, go to BLANK.
    - Else: pulse frame_tick, index <= 0, go to BLANK. If pending=1, copy shadow to active, clear pending, pulse load_ack in the same cycle.
- Timing:
  - Each digit slot is exactly BLANK_CYCLES+SHOW_CYCLES cycles.
  - A frame is NUM_DIGITS*(BLANK_CYCLES+SHOW_CYCLES) cycles.
  - All outputs are registered (one cycle after the state decision). No combinational path from inputs to outputs.
- Boundary and simultaneous-event rules:
  - load in the same cycle as the frame-end transfer: the old shadow is transferred and load_ack pulses. The new data is captured into the shadow with pending kept at 1 and is applied at the next frame end.
  - enable deasserted mid-slot: next cycle go to IDLE, an_n all 1, index and timer reset to 0. Pending is kept.
  - Reset mid-operation: all outputs and state return to reset values immediately (asynchronous). Shadow and pending are cleared.
  - Index wraps NUM_DIGITS-1 -> 0. No other values are reachable.
  - An anode is never driven low during BLANK. At most one an_n bit is low at any time.

Test Plan:
- Bench parameters for all scenarios: NUM_DIGITS=4, SHOW=4, BLANK=1.
- Reset then enable=1 with load never asserted -> an_n cycles 1110,1101,1011,0111, each low for 4 cycles separated by 1 cycle of 1111. dig_code=0 throughout. frame_tick pulses every 20 cycles.
- load with data_in=16'h4321, dp_in=4'b0100 while idle, then enable=1 -> load_ack at the IDLE->BLANK transition. dig_code 1,2,3,4 on digits 0..3. dp_n=0 only while an_n=1011.
- Mid-frame load of 16'hABCD followed by a second load of 16'h5678 before frame end -> the current frame keeps its old values. A single load_ack coincides with frame_tick. The next frame shows 8,7,6,5.
- blank_in=4'b0010 -> an_n stays 1111 during digit 1's SHOW slot. Slot timing is unchanged (frame is still 20 cycles).
- enable dropped during digit 2's SHOW, then re-raised -> an_n=1111 the next cycle. Scan restarts at digit 0 after 1 blank cycle.
- rst pulsed mid-SHOW -> an_n=1111, dp_n=1, dig_code=0 immediately, without waiting for a clock edge. The previously loaded data is gone (dig_code=0 after re-enable).
